// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator: registered coordinates, blank, syncs, markers.
// Optional VGA_SYNC_ALIGN_EN delays hs/vs one clock to line up with colour regs.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] hc;
  logic [9:0] vc;
  logic [7:0] frame_cnt_q;
  logic       hs_q;
  logic       vs_q;
  logic       blank_d;
  logic       hs_d;
  logic       vs_d;
  logic       origin;

  // Decode the current counter position
  always_comb begin
    blank_d = (hc < H_VIS) && (vc < V_VIS);
    hs_d    = !((hc >= HS_BEG) && (hc < HS_END));
    vs_d    = !((vc >= VS_BEG) && (vc < VS_END));
    origin  = (hc == 10'd0) && (vc == 10'd0);
  end

  // Free-running pixel and line counters
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc <= 10'd0;
      vc <= 10'd0;
    end else if (hc == H_LAST) begin
      hc <= 10'd0;
      vc <= (vc == V_LAST) ? 10'd0 : vc + 10'd1;
    end else begin
      hc <= hc + 10'd1;
    end
  end

  // Single output register stage, all outputs coherent
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      DrawX       <= 10'd0;
      DrawY       <= 10'd0;
      blank       <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      DrawX       <= hc;
      DrawY       <= vc;
      blank       <= blank_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      line_start  <= (hc == 10'd0);
      frame_start <= origin;
      frame_cnt_q <= frame_cnt_q + {7'd0, origin};
    end
  end

  assign frame_count = frame_cnt_q;

`ifdef VGA_SYNC_ALIGN_EN
  logic hs_dly;
  logic vs_dly;

  // Extra sync stage to match downstream colour register latency
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_dly <= 1'b1;
      vs_dly <= 1'b1;
    end else begin
      hs_dly <= hs_q;
      vs_dly <= vs_q;
    end
  end

  assign hs = hs_dly;
  assign vs = vs_dly;
`else
  assign hs = hs_q;
  assign vs = vs_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: cycle model from linear pixel index.
// Counter deposits (force/release) skip through the long frame.
module tb_vga_timing_gen;

  localparam int HT    = 800;
  localparam int VT    = 525;
  localparam int FRAME = HT * VT;

  logic       vga_clk;
  logic       reset_n;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  vga_timing_gen dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .hs          (hs),
    .vs          (vs),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame_count (frame_count)
  );

  initial vga_clk = 1'b0;
  always #20 vga_clk = ~vga_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: next linear pixel index to be shown
  int t;
  int fc;
  bit hs_prev;
  bit vs_prev;

  // Statistics over observed outputs
  int hs_low;
  int vs_low;
  int blank_cnt;
  int ls_cnt;
  int y_max;
  int fall_x;
  bit last_hs;

`ifdef VGA_SYNC_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_x", 32'(DrawX), 0);
    chk("rst_y", 32'(DrawY), 0);
    chk("rst_blank", 32'(blank), 0);
    chk("rst_hs", 32'(hs), 1);
    chk("rst_vs", 32'(vs), 1);
    chk("rst_ls", 32'(line_start), 0);
    chk("rst_fs", 32'(frame_start), 0);
    chk("rst_fc", 32'(frame_count), 0);
  endtask

  task automatic clr_stats();
    hs_low = 0; vs_low = 0; blank_cnt = 0; ls_cnt = 0;
    fall_x = -1; last_hs = hs;
  endtask

  // One clock: compare every output with the model, then advance
  task automatic step();
    int x, y;
    bit e_blank, e_hs, e_vs;
    @(posedge vga_clk);
    #1;
    x = t % HT;
    y = t / HT;
    if (t == 0) fc = (fc + 1) % 256;
    e_blank = (x < 640) && (y < 480);
    e_hs = !((x >= 656) && (x < 752));
    e_vs = !((y >= 490) && (y < 492));
    chk("drawx", 32'(DrawX), 32'(x));
    chk("drawy", 32'(DrawY), 32'(y));
    chk("blank", 32'(blank), 32'(e_blank));
    chk("hs", 32'(hs), ALIGN ? 32'(hs_prev) : 32'(e_hs));
    chk("vs", 32'(vs), ALIGN ? 32'(vs_prev) : 32'(e_vs));
    chk("line_start", 32'(line_start), 32'(x == 0));
    chk("frame_start", 32'(frame_start), 32'(t == 0));
    chk("frame_count", 32'(frame_count), 32'(fc));
    hs_prev = e_hs;
    vs_prev = e_vs;
    t = (t + 1) % FRAME;
    if (hs == 1'b0) hs_low++;
    if (vs == 1'b0) vs_low++;
    if (blank) blank_cnt++;
    if (line_start) ls_cnt++;
    if (int'(DrawY) > y_max) y_max = int'(DrawY);
    if (last_hs && !hs && fall_x < 0) fall_x = int'(DrawX);
    last_hs = hs;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Deposit a new counter position between clock edges
  task automatic jump(input int pos);
    @(negedge vga_clk);
    force dut.hc = 10'(pos % HT);
    force dut.vc = 10'(pos / HT);
    #1;
    release dut.hc;
    release dut.vc;
    t = pos;
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    #1;
    chk_reset();
    for (int i = 0; i < cycles; i++) begin
      @(posedge vga_clk);
      #1;
      chk_reset();
    end
    @(negedge vga_clk);
    reset_n = 1'b1;
    t = 0; fc = 0; hs_prev = 1'b1; vs_prev = 1'b1;
  endtask

  initial begin
    #10ms;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pos;
    y_max = 0;
    reset_n = 1'b1;
    #3;
    do_reset(5);

    // One full line from reset release
    clr_stats();
    run(HT);
    chk("line_hs_low", 32'(hs_low), 96);
    chk("line_blank", 32'(blank_cnt), 640);
    chk("line_ls", 32'(ls_cnt), 1);

    // Frame wrap: (799,524) -> (0,0), frame_count 1 -> 2
    jump(FRAME - $urandom_range(2, 30));
    while (t != 0) step();
    step();
    chk("wrap_fc", 32'(frame_count), 2);
    chk("wrap_fs", 32'(frame_start), 1);

    // Vertical sync window over lines 489..491
    jump(489 * HT);
    clr_stats();
    run(3 * HT);
    chk("vs_low", 32'(vs_low), 1600);

    // frame_count wrap 255 -> 0
    @(negedge vga_clk);
    force dut.frame_cnt_q = 8'd255;
    #1;
    release dut.frame_cnt_q;
    fc = 255;
    jump(FRAME - $urandom_range(2, 30));
    while (t != 0) step();
    step();
    chk("fc_wrap", 32'(frame_count), 0);

    // Random positions and run lengths
    for (int k = 0; k < 6; k++) begin
      pos = int'($urandom_range(0, FRAME - 1));
      jump(pos);
      run(int'($urandom_range(50, 900)));
    end

    // Mid-frame asynchronous reset at (700,300)
    jump(300 * HT + 690);
    while (t != 300 * HT + 701) step();
    chk("pre_rst_x", 32'(DrawX), 700);
    #5;
    do_reset(int'($urandom_range(1, 5)));
    clr_stats();
    run(1000);
    chk("hs_fall_x", 32'(fall_x), ALIGN ? 657 : 656);
    chk("y_max", 32'(y_max <= 524), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
